regfile_wb_arbiter: RTL and testbench

//  - Shares the single register-file write port (regWrite/writeReg/writeData) between two

---
 rtl/regfile_wb_arbiter.sv | 174 +++++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Shares the single register-file write port between two writeback
//   requesters. Port 0 is ALU writeback and port 1 is memory-load writeback.
//   Arbitration is round-robin with a valid/ready handshake. The write-port
//   outputs are registered. A per-register pending scoreboard lets the
//   multi-cycle controller stall reads of registers that still have a
//   writeback outstanding.
//
// Ports
//   clock, rst                     single clock; synchronous active-high reset
//   r0_valid/r0_addr/r0_data       port 0 write request
//   r0_ready                       port 0 grant (transfer = valid & ready)
//   r1_valid/r1_addr/r1_data       port 1 write request
//   r1_ready                       port 1 grant
//   rsv_valid/rsv_addr             mark rsv_addr as pending (instruction issued)
//   readReg1/readReg2              hazard-check addresses
//   hazard1/hazard2                pend[readReg1] / pend[readReg2]
//   regWrite/writeReg/writeData    registered register-file write port
//   pend                           scoreboard bit vector
//
// Configuration macro
//   ZERO_REG_EN  register 0 is hardwired to zero. Writes to it are accepted
//                but never issued, it is never marked pending, and it never
//                reports a hazard. When the macro is undefined, register 0
//                behaves like every other register.
module regfile_wb_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int NREGS  = 8
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              r0_valid,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_data,
  output logic              r0_ready,
  input  logic              r1_valid,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_data,
  output logic              r1_ready,
  input  logic              rsv_valid,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic [ADDR_W-1:0] readReg1,
  input  logic [ADDR_W-1:0] readReg2,
  output logic              hazard1,
  output logic              hazard2,
  output logic              regWrite,
  output logic [ADDR_W-1:0] writeReg,
  output logic [DATA_W-1:0] writeData,
  output logic [NREGS-1:0]  pend
);

  typedef enum logic {
    PRI0 = 1'b0,
    PRI1 = 1'b1
  } pri_t;

  pri_t              pri_reg, pri_next;
  logic              grant0, grant1;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;
  logic              zero_hit;
  logic              wr_en_next;
  logic              rsv_ok;

  logic              wr_en_reg;
  logic [ADDR_W-1:0] write_addr_reg;
  logic [DATA_W-1:0] write_data_reg;
  logic [NREGS-1:0]  pend_reg, pend_next;

  // Priority state register
  always_ff @(posedge clock) begin
    if (rst) begin
      pri_reg <= PRI0;
    end else begin
      pri_reg <= pri_next;
    end
  end

  // Grant decode and next priority. Reset suppresses grants, so a request
  // that is present during reset is not accepted. The favoured port
  // changes only when both ports compete.
  always_comb begin
    pri_next = pri_reg;
    grant0   = 1'b0;
    grant1   = 1'b0;
    if (!rst) begin
      case ({r0_valid, r1_valid})
        2'b10: grant0 = 1'b1;
        2'b01: grant1 = 1'b1;
        2'b11: begin
          if (pri_reg == PRI0) begin
            grant0   = 1'b1;
            pri_next = PRI1;
          end else begin
            grant1   = 1'b1;
            pri_next = PRI0;
          end
        end
        default: ;
      endcase
    end
  end

  assign r0_ready = grant0;
  assign r1_ready = grant1;

  assign win_addr = grant1 ? r1_addr : r0_addr;
  assign win_data = grant1 ? r1_data : r0_data;

`ifdef ZERO_REG_EN
  // A write to the hardwired-zero register is accepted but never issued.
  assign zero_hit = (win_addr == '0);
  assign rsv_ok   = (rsv_addr != '0);
`else
  assign zero_hit = 1'b0;
  assign rsv_ok   = 1'b1;
`endif

  assign wr_en_next = (grant0 | grant1) & ~zero_hit;

  // Registered write port. The address and data hold their previous values
  // when no write is issued.
  always_ff @(posedge clock) begin
    if (rst) begin
      wr_en_reg      <= 1'b0;
      write_addr_reg <= '0;
      write_data_reg <= '0;
    end else begin
      wr_en_reg <= wr_en_next;
      if (wr_en_next) begin
        write_addr_reg <= win_addr;
        write_data_reg <= win_data;
      end
    end
  end

  // Scoreboard. A reservation in the same cycle as the retiring writeback
  // for the same register wins. That reservation belongs to a newer
  // instruction, so the register is still pending.
  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_pend
      logic set_bit, clr_bit;
      assign set_bit = rsv_valid && rsv_ok && (rsv_addr == ADDR_W'(gi));
      assign clr_bit = wr_en_reg && (write_addr_reg == ADDR_W'(gi));
      assign pend_next[gi] = set_bit | (pend_reg[gi] & ~clr_bit);
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (rst) begin
      pend_reg <= '0;
    end else begin
      pend_reg <= pend_next;
    end
  end

  // Hazards come only from registered state. They therefore have no
  // combinational path from the requester handshakes.
`ifdef ZERO_REG_EN
  assign hazard1 = pend_reg[readReg1] & (readReg1 != '0);
  assign hazard2 = pend_reg[readReg2] & (readReg2 != '0);
`else
  assign hazard1 = pend_reg[readReg1];
  assign hazard2 = pend_reg[readReg2];
`endif

  assign regWrite  = wr_en_reg;
  assign writeReg  = write_addr_reg;
  assign writeData = write_data_reg;
  assign pend      = pend_reg;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter. It runs directed scenarios followed by
// randomized traffic. All outputs are compared every cycle against a
// rule-level reference model.
module tb_regfile_wb_arbiter;
  localparam int DW = 16;
  localparam int AW = 3;
  localparam int NR = 8;
`ifdef ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          rst;
  logic          r0_valid, r1_valid, rsv_valid;
  logic [AW-1:0] r0_addr, r1_addr, rsv_addr, readReg1, readReg2;
  logic [DW-1:0] r0_data, r1_data;
  logic          r0_ready, r1_ready, hazard1, hazard2, regWrite;
  logic [AW-1:0] writeReg;
  logic [DW-1:0] writeData;
  logic [NR-1:0] pend;

  regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .NREGS(NR)) dut (
    .clock(clock), .rst(rst),
    .r0_valid(r0_valid), .r0_addr(r0_addr), .r0_data(r0_data), .r0_ready(r0_ready),
    .r1_valid(r1_valid), .r1_addr(r1_addr), .r1_data(r1_data), .r1_ready(r1_ready),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
    .readReg1(readReg1), .readReg2(readReg2),
    .hazard1(hazard1), .hazard2(hazard2),
    .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData), .pend(pend)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model state. m_fav1 means port 1 wins the next tie.
  bit            m_fav1;
  bit            m_rw;
  logic [AW-1:0] m_wr;
  logic [DW-1:0] m_wd;
  bit            m_pend[NR];

  int   exp_g;            // 0 none, 1 port 0, 2 port 1
  logic obs_r0, obs_r1, obs_h1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NR-1:0] pend_vec();
    logic [NR-1:0] v;
    for (int i = 0; i < NR; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic model_reset();
    m_fav1 = 1'b0;
    m_rw   = 1'b0;
    m_wr   = '0;
    m_wd   = '0;
    for (int i = 0; i < NR; i++) m_pend[i] = 1'b0;
  endtask

  task automatic idle();
    r0_valid = 1'b0; r1_valid = 1'b0; rsv_valid = 1'b0;
  endtask

  // Called at posedge+1 with the inputs already set. Checks outputs
  // mid-cycle, then advances the model at the posedge. Returns at posedge+1.
  task automatic cycle();
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    bit            h1, h2;
    #4;
    exp_g = 0;
    if (!rst) begin
      if (r0_valid && !r1_valid)      exp_g = 1;
      else if (!r0_valid && r1_valid) exp_g = 2;
      else if (r0_valid && r1_valid)  exp_g = m_fav1 ? 2 : 1;
    end
    h1 = m_pend[readReg1] && !(ZR && readReg1 == 0);
    h2 = m_pend[readReg2] && !(ZR && readReg2 == 0);
    chk("r0_ready",  32'(r0_ready),  32'(exp_g == 1));
    chk("r1_ready",  32'(r1_ready),  32'(exp_g == 2));
    chk("regWrite",  32'(regWrite),  32'(m_rw));
    chk("writeReg",  32'(writeReg),  32'(m_wr));
    chk("writeData", 32'(writeData), 32'(m_wd));
    chk("pend",      32'(pend),      32'(pend_vec()));
    chk("hazard1",   32'(hazard1),   32'(h1));
    chk("hazard2",   32'(hazard2),   32'(h2));
    obs_r0 = r0_ready; obs_r1 = r1_ready; obs_h1 = hazard1;
    @(posedge clock);
    if (rst) begin
      model_reset();
    end else begin
      if (m_rw) m_pend[m_wr] = 1'b0;
      if (rsv_valid && !(ZR && rsv_addr == 0)) m_pend[rsv_addr] = 1'b1;
      if (r0_valid && r1_valid) m_fav1 = !m_fav1;
      if (exp_g != 0) begin
        a = (exp_g == 1) ? r0_addr : r1_addr;
        d = (exp_g == 1) ? r0_data : r1_data;
        if (ZR && a == 0) m_rw = 1'b0;
        else begin
          m_rw = 1'b1; m_wr = a; m_wd = d;
        end
      end else begin
        m_rw = 1'b0;
      end
    end
    #1;
  endtask

  task automatic reset_cycle();
    rst = 1'b1; idle(); cycle(); rst = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] qa[4];
    logic [DW-1:0] qb[4];
    int i0, i1, ng;
    int gseq[8];

    rst = 1'b1; idle();
    r0_addr = '0; r1_addr = '0; r0_data = '0; r1_data = '0;
    rsv_addr = '0; readReg1 = '0; readReg2 = '0;
    @(posedge clock); #1;
    model_reset();

    // Reset with both requesters active
    r0_valid = 1'b1; r0_addr = 3'd1; r0_data = 16'h0101;
    r1_valid = 1'b1; r1_addr = 3'd2; r1_data = 16'h0202;
    cycle(); cycle();
    chk("rst_regWrite", 32'(regWrite), 32'd0);
    chk("rst_pend",     32'(pend),     32'd0);
    rst = 1'b0;
    cycle();
    chk("rst_first_grant_r0", 32'(obs_r0), 32'd1);
    chk("rst_first_grant_r1", 32'(obs_r1), 32'd0);
    idle(); cycle();

    // Single requester on port 1
    r1_valid = 1'b1; r1_addr = 3'd5; r1_data = 16'hBEEF;
    cycle();
    chk("single_ready", 32'(obs_r1), 32'd1);
    chk("single_wen",   32'(regWrite), 32'd1);
    chk("single_addr",  32'(writeReg), 32'd5);
    chk("single_data",  32'(writeData), 32'hBEEF);
    idle(); cycle();
    chk("single_wen_off", 32'(regWrite), 32'd0);

    // Contention: alternating grants, a write every cycle
    reset_cycle();
    for (int k = 0; k < 4; k++) begin
      qa[k] = 16'hA000 + 16'(k);
      qb[k] = 16'hB000 + 16'(k);
    end
    i0 = 0; i1 = 0; ng = 0;
    for (int c = 0; c < 8; c++) begin
      r0_valid = (i0 < 4); r0_addr = 3'd1; r0_data = qa[i0 < 4 ? i0 : 3];
      r1_valid = (i1 < 4); r1_addr = 3'd2; r1_data = qb[i1 < 4 ? i1 : 3];
      cycle();
      gseq[c] = obs_r1 ? 1 : (obs_r0 ? 0 : 9);
      if (exp_g == 1) i0++;
      if (exp_g == 2) i1++;
      if (regWrite) ng++;
    end
    for (int k = 0; k < 4; k++) chk($sformatf("contention_grant%0d", k), 32'(gseq[k]), 32'(k % 2));
    chk("contention_writes", 32'(ng), 32'd8);
    idle(); cycle();

    // Same destination on both ports
    reset_cycle();
    r0_valid = 1'b1; r0_addr = 3'd3; r0_data = 16'h1111;
    r1_valid = 1'b1; r1_addr = 3'd3; r1_data = 16'h2222;
    cycle();
    chk("same_first",  32'(writeData), 32'h1111);
    r0_valid = 1'b0;
    cycle();
    chk("same_second", 32'(writeData), 32'h2222);
    chk("same_addr",   32'(writeReg),  32'd3);
    idle(); cycle();

    // Scoreboard set, hazard, coincident set/clear, clear
    reset_cycle();
    rsv_valid = 1'b1; rsv_addr = 3'd4;
    cycle();
    chk("sb_set", 32'(pend), 32'h10);
    rsv_valid = 1'b0; readReg1 = 3'd4;
    cycle();
    chk("sb_hazard1", 32'(obs_h1), 32'd1);
    r0_valid = 1'b1; r0_addr = 3'd4; r0_data = 16'h4444;
    cycle();
    r0_valid = 1'b0; rsv_valid = 1'b1; rsv_addr = 3'd4;
    cycle();
    chk("sb_set_wins", 32'(pend), 32'h10);
    idle(); cycle();
    chk("sb_hold", 32'(pend), 32'h10);
    r0_valid = 1'b1; r0_addr = 3'd4; r0_data = 16'h4545;
    cycle();
    idle(); cycle();
    chk("sb_clear", 32'(pend), 32'h0);

    // Register 0 behaviour
    r0_valid = 1'b1; r0_addr = 3'd0; r0_data = 16'h1234;
    cycle();
    chk("zero_ready", 32'(obs_r0),   32'd1);
    chk("zero_wen",   32'(regWrite), ZR ? 32'd0 : 32'd1);
    chk("zero_addr",  32'(writeReg), ZR ? 32'd4 : 32'd0);
    idle(); rsv_valid = 1'b1; rsv_addr = 3'd0;
    cycle();
    chk("zero_rsv", 32'(pend), ZR ? 32'd0 : 32'd1);
    idle(); cycle();

    // Randomized traffic. Requests are held until they are granted.
    reset_cycle();
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(63) == 0);
      if (!r0_valid && $urandom_range(2) != 0) begin
        r0_valid = 1'b1; r0_addr = AW'($urandom); r0_data = DW'($urandom);
      end
      if (!r1_valid && $urandom_range(2) != 0) begin
        r1_valid = 1'b1; r1_addr = AW'($urandom); r1_data = DW'($urandom);
      end
      rsv_valid = ($urandom_range(1) == 1);
      rsv_addr  = AW'($urandom);
      readReg1  = AW'($urandom);
      readReg2  = AW'($urandom);
      cycle();
      if (exp_g == 1) r0_valid = 1'b0;
      if (exp_g == 2) r1_valid = 1'b0;
    end
    rst = 1'b0; idle(); cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
